// File: rtl/nes_pad_responder_if.sv
// Serial pad bus between the console-side poller (master) and the pad responder (slave).
interface nes_pad_responder_if;
    logic       latch;
    logic       pulse;
    logic       button_data;
    logic [3:0] bit_index;
    logic       frame_done;

    modport master (
        output latch,
        output pulse,
        input  button_data,
        input  bit_index,
        input  frame_done
    );

    modport slave (
        input  latch,
        input  pulse,
        output button_data,
        output bit_index,
        output frame_done
    );
endinterface

// File: rtl/nes_pad_responder.sv
// NES pad emulation: debounced switches loaded on latch and shifted out, active-low, on pulse.
module nes_pad_responder #(
    parameter int   DEBOUNCE_CYCLES = 400000,
    parameter logic FILL_LEVEL      = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 buttons,
    nes_pad_responder_if.slave         pad
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [18:0] DB_MAX = 19'(DEBOUNCE_CYCLES - 1);

    // Three-flop chains: flops 1-2 resynchronise, flop 3 gives the previous value for edge detect.
    logic [2:0]  latch_sync_q, latch_sync_d;
    logic [2:0]  pulse_sync_q, pulse_sync_d;

    logic [7:0]  debounced_q, debounced_d;
    logic [18:0] db_cnt_q [8];
    logic [18:0] db_cnt_d [8];

    state_t      state_q, state_d;
    logic [7:0]  sreg_q, sreg_d;
    logic [3:0]  bit_index_q, bit_index_d;
    logic        button_data_q, button_data_d;
    logic        frame_done_q, frame_done_d;

    logic        latch_s, latch_fall, pulse_rise;

    assign latch_s    = latch_sync_q[1];
    assign latch_fall = ~latch_sync_q[1] & latch_sync_q[2];
    assign pulse_rise = pulse_sync_q[1] & ~pulse_sync_q[2];

    always_comb begin
        latch_sync_d = {latch_sync_q[1:0], pad.latch};
        pulse_sync_d = {pulse_sync_q[1:0], pad.pulse};
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        debounced_d = debounced_q;
        for (int i = 0; i < 8; i++) begin
            db_cnt_d[i] = '0;
            if (buttons[i] != debounced_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    debounced_d[i] = buttons[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 19'd1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        bit_index_d   = bit_index_q;
        button_data_d = button_data_q;
        frame_done_d  = 1'b0;

        if (latch_s) begin
            // Latch dominates everything, including a coincident pulse edge.
            state_d       = LOAD;
            sreg_d        = debounced_q;
            bit_index_d   = 4'd0;
            button_data_d = ~debounced_q[0];
        end else begin
            unique case (state_q)
                IDLE: ;
                LOAD: begin
                    if (latch_fall) state_d = SHIFT;
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        sreg_d      = {1'b0, sreg_q[7:1]};
                        bit_index_d = bit_index_q + 4'd1;
                        if (bit_index_q == 4'd7) begin
                            button_data_d = FILL_LEVEL;
                            frame_done_d  = 1'b1;
                            state_d       = DONE;
                        end else begin
                            button_data_d = ~sreg_q[1];
                        end
                    end
                end
                DONE: button_data_d = FILL_LEVEL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            latch_sync_q  <= '0;
            pulse_sync_q  <= '0;
            debounced_q   <= '0;
            state_q       <= IDLE;
            sreg_q        <= 8'h00;
            bit_index_q   <= 4'd0;
            button_data_q <= 1'b1;
            frame_done_q  <= 1'b0;
            // NOTE: the counter array is ordinary flops, not RAM, so it is reset with the rest.
            for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
        end else begin
            latch_sync_q  <= latch_sync_d;
            pulse_sync_q  <= pulse_sync_d;
            debounced_q   <= debounced_d;
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            bit_index_q   <= bit_index_d;
            button_data_q <= button_data_d;
            frame_done_q  <= frame_done_d;
            for (int i = 0; i < 8; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign pad.button_data = button_data_q;
    assign pad.bit_index   = bit_index_q;
    assign pad.frame_done  = frame_done_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: table of full frames plus hand-written corner sequences.
module tb_nes_pad_responder;

    logic       clk;
    logic       reset;
    logic [7:0] buttons;
    int         vectors;
    int         errors;
    int         fd_count;

    nes_pad_responder_if pad_if ();

    nes_pad_responder #(
        .DEBOUNCE_CYCLES(4),
        .FILL_LEVEL     (1'b0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .buttons(buttons),
        .pad    (pad_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // frame_done is one cycle wide, so each pulse is seen exactly once on the falling edge.
    always @(negedge clk) if (!reset && pad_if.frame_done) fd_count++;

    typedef struct {
        logic [7:0] buttons;
        logic [7:0] exp_serial;   // bit i = expected button_data after i pulses
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch(input int hi);
        @(negedge clk);
        pad_if.latch = 1'b1;
        wait_cyc(hi);
        pad_if.latch = 1'b0;
        wait_cyc(6);
    endtask

    task automatic do_pulse();
        pad_if.pulse = 1'b1;
        wait_cyc(6);
        pad_if.pulse = 1'b0;
        wait_cyc(6);
    endtask

    task automatic run_frame(input logic [7:0] btn, input logic [7:0] exp_serial);
        int fd0;
        buttons = btn;
        wait_cyc(8);
        do_latch(12);
        fd0 = fd_count;
        check($sformatf("frame %02h bit0", btn), 32'(pad_if.button_data), 32'(exp_serial[0]));
        for (int i = 1; i < 8; i++) begin
            do_pulse();
            check($sformatf("frame %02h bit%0d", btn, i), 32'(pad_if.button_data), 32'(exp_serial[i]));
        end
        do_pulse();
        check($sformatf("frame %02h fill", btn), 32'(pad_if.button_data), 32'h0);
        check($sformatf("frame %02h bit_index", btn), 32'(pad_if.bit_index), 32'd8);
        check($sformatf("frame %02h frame_done count", btn), 32'(fd_count - fd0), 32'd1);
    endtask

    initial begin
        int fd0;
        vectors      = 0;
        errors       = 0;
        fd_count     = 0;
        reset        = 1'b1;
        buttons      = 8'h00;
        pad_if.latch = 1'b0;
        pad_if.pulse = 1'b0;

        vecs[0] = '{buttons: 8'b0000_1001, exp_serial: 8'hF6};
        vecs[1] = '{buttons: 8'hFF,        exp_serial: 8'h00};
        vecs[2] = '{buttons: 8'h00,        exp_serial: 8'hFF};
        vecs[3] = '{buttons: 8'hA5,        exp_serial: 8'h5A};
        vecs[4] = '{buttons: 8'h80,        exp_serial: 8'h7F};

        wait_cyc(3);
        check("reset button_data", 32'(pad_if.button_data), 32'h1);
        check("reset bit_index", 32'(pad_if.bit_index), 32'd0);
        check("reset frame_done", 32'(pad_if.frame_done), 32'h0);
        reset = 1'b0;

        // Pulses in IDLE are ignored.
        buttons = 8'hFF;
        wait_cyc(8);
        for (int i = 0; i < 3; i++) do_pulse();
        check("idle pulse bit_index", 32'(pad_if.bit_index), 32'd0);
        check("idle pulse button_data", 32'(pad_if.button_data), 32'h1);

        foreach (vecs[i]) run_frame(vecs[i].buttons, vecs[i].exp_serial);

        // Pulses after the 8th shift: data stays at fill, no new frame_done.
        fd0 = fd_count;
        for (int i = 0; i < 4; i++) do_pulse();
        check("extra pulse button_data", 32'(pad_if.button_data), 32'h0);
        check("extra pulse bit_index", 32'(pad_if.bit_index), 32'd8);
        check("extra pulse frame_done", 32'(fd_count - fd0), 32'd0);

        // Pulse while latch is held high does not shift.
        buttons = 8'h09;
        wait_cyc(8);
        @(negedge clk);
        pad_if.latch = 1'b1;
        wait_cyc(6);
        do_pulse();
        check("pulse under latch bit_index", 32'(pad_if.bit_index), 32'd0);
        check("pulse under latch button_data", 32'(pad_if.button_data), 32'h0);
        pad_if.latch = 1'b0;
        wait_cyc(6);
        check("after latch bit_index", 32'(pad_if.bit_index), 32'd0);

        // Re-latch mid-frame with new buttons.
        for (int i = 0; i < 3; i++) do_pulse();
        check("mid-frame bit_index", 32'(pad_if.bit_index), 32'd3);
        buttons = 8'h80;
        wait_cyc(10);
        check("in-flight frame unaffected", 32'(pad_if.button_data), 32'h0);
        @(negedge clk);
        pad_if.latch = 1'b1;
        wait_cyc(6);
        check("relatch bit_index", 32'(pad_if.bit_index), 32'd0);
        check("relatch button_data", 32'(pad_if.button_data), 32'h1);
        pad_if.latch = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < 7; i++) do_pulse();
        check("relatch Right bit", 32'(pad_if.button_data), 32'h0);
        check("relatch bit_index 7", 32'(pad_if.bit_index), 32'd7);

        // Glitch on B shorter than the debounce time is rejected.
        buttons = 8'h00;
        wait_cyc(8);
        @(negedge clk);
        buttons = 8'h02;
        wait_cyc(3);
        buttons = 8'h00;
        wait_cyc(2);
        do_latch(12);
        do_pulse();
        check("glitch B not pressed", 32'(pad_if.button_data), 32'h1);
        buttons = 8'h02;
        wait_cyc(8);
        do_latch(12);
        do_pulse();
        check("held B pressed", 32'(pad_if.button_data), 32'h0);

        // Reset mid-frame at bit_index 5, then an immediate latch sees cleared debounce state.
        buttons = 8'hFF;
        wait_cyc(8);
        do_latch(12);
        for (int i = 0; i < 5; i++) do_pulse();
        check("pre-reset bit_index", 32'(pad_if.bit_index), 32'd5);
        check("pre-reset button_data", 32'(pad_if.button_data), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("mid-frame reset button_data", 32'(pad_if.button_data), 32'h1);
        check("mid-frame reset bit_index", 32'(pad_if.bit_index), 32'd0);
        reset        = 1'b0;
        pad_if.latch = 1'b1;
        @(negedge clk);
        pad_if.latch = 1'b0;
        wait_cyc(6);
        check("post-reset load undebounced", 32'(pad_if.button_data), 32'h1);
        do_pulse();
        check("post-reset shift undebounced", 32'(pad_if.button_data), 32'h1);
        check("post-reset shift bit_index", 32'(pad_if.bit_index), 32'd1);
        wait_cyc(8);
        do_latch(12);
        check("post-reset redebounced", 32'(pad_if.button_data), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
